// File: rtl/ddr4_axi_pkg.sv
// Shared AXI4 encodings and the frame-reader state type, also used by the write path.
package ddr4_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [2:0] AXI_SIZE_8B     = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT
  } rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an occupancy count output.
module sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic [DATA_W-1:0]         pop_data,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign do_push  = push && (count != FULL_CNT);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ddr4_frame_reader.sv
// AXI4 read master fetching one frame per start into a beat FIFO that feeds the pixel stream.
module ddr4_frame_reader
  import ddr4_axi_pkg::*;
#(
  parameter int ADDR_W     = 31,
  parameter int DATA_W     = 64,
  parameter int ID_W       = 4,
  parameter int AXI_ID     = 0,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int BEATS_W    = 24
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [BEATS_W-1:0]  frame_beats_i,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  output logic [DATA_W-1:0]   pix_data_o,
  output logic                pix_valid_o,
  input  logic                pix_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BB_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  rd_state_e            state;
  rd_state_e            state_nx;
  logic [ADDR_W-1:0]    addr;
  logic [BEATS_W-1:0]   rem_ar;
  logic [BEATS_W-1:0]   rem_r;
  logic [BEATS_W-1:0]   nbeats;
  logic [CNT_W-1:0]     nbeats_c;
  logic [CNT_W-1:0]     reserved;
  logic [CNT_W-1:0]     credits;
  logic [CNT_W-1:0]     fifo_count;
  logic [BB_W-1:0]      beat_idx;
  logic                 fifo_empty;
  logic                 ar_fire;
  logic                 r_fire;
  logic                 last_beat;
  logic                 burst_end;
  logic                 done;
  logic                 err;
  logic                 unused_rid;

  assign unused_rid = ^m_axi_rid;

  // Credits count FIFO slots not yet filled or promised to an outstanding burst.
  assign nbeats    = (rem_ar > BEATS_W'(BURST_LEN)) ? BEATS_W'(BURST_LEN) : rem_ar;
  assign nbeats_c  = CNT_W'(nbeats);
  assign credits   = CNT_W'(FIFO_DEPTH) - fifo_count - reserved;

  assign m_axi_araddr  = addr;
  assign m_axi_arlen   = 8'(nbeats - BEATS_W'(1));
  assign m_axi_arsize  = AXI_SIZE_8B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arid    = ID_W'(AXI_ID);
  assign m_axi_arvalid = (state == ST_ADDR) && (credits >= nbeats_c);
  assign m_axi_rready  = 1'b1;

  assign ar_fire   = m_axi_arvalid && m_axi_arready;
  assign r_fire    = m_axi_rvalid && (state != ST_IDLE);
  assign last_beat = r_fire && (rem_r == BEATS_W'(1));
  // Every burst is full length except possibly the frame's tail.
  assign burst_end = (beat_idx == BB_W'(BURST_LEN - 1)) || (rem_r == BEATS_W'(1));

  assign busy_o = (state != ST_IDLE);
  assign done_o = done;
  assign err_o  = err;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start_i) state_nx = ST_ADDR;
      ST_ADDR: if (ar_fire && (rem_ar == nbeats)) state_nx = ST_WAIT;
      ST_WAIT: if (last_beat) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rem_ar   <= '0;
      rem_r    <= '0;
      reserved <= '0;
      beat_idx <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done     <= last_beat;
      reserved <= reserved + (ar_fire ? nbeats_c : '0) - (r_fire ? CNT_W'(1) : '0);
      if (start_i && (state == ST_IDLE)) begin
        rem_ar   <= frame_beats_i;
        rem_r    <= frame_beats_i;
        beat_idx <= '0;
        err      <= 1'b0;
      end else begin
        if (ar_fire) rem_ar <= rem_ar - nbeats;
        if (r_fire) begin
          rem_r    <= rem_r - BEATS_W'(1);
          beat_idx <= burst_end ? '0 : beat_idx + BB_W'(1);
          if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != burst_end)) err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (start_i && (state == ST_IDLE)) addr <= base_addr_i;
    else if (ar_fire)                  addr <= addr + ADDR_W'(nbeats) * ADDR_W'(DATA_W / 8);
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .push      (r_fire),
    .push_data (m_axi_rdata),
    .pop       (pix_valid_o && pix_ready_i),
    .pop_data  (pix_data_o),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign pix_valid_o = !fifo_empty;

endmodule

// File: tb/tb_ddr4_frame_reader.sv
// Bench for ddr4_frame_reader: randomized AXI slave plus a frame-level reference model.
module tb_ddr4_frame_reader;
  import ddr4_axi_pkg::*;

  localparam int ADDR_W     = 31;
  localparam int DATA_W     = 64;
  localparam int ID_W       = 4;
  localparam int BURST_LEN  = 16;
  localparam int FIFO_DEPTH = 64;
  localparam int BEATS_W    = 24;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   base = '0;
  logic [BEATS_W-1:0]  frame_beats = '0;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [ID_W-1:0]     arid;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic [ID_W-1:0]     rid;
  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   pix_data;
  logic                pix_valid;
  logic                pix_ready;
  logic                busy;
  logic                done;
  logic                err;

  int checks = 0;
  int errors = 0;

  // slave / stream knobs
  int          ar_pct = 100, r_pct = 100, pix_pct = 100;
  bit          ar_force_low = 1'b0;
  int          err_beat = -1, early_last_beat = -1;
  logic [31:0] seed = 32'h0;

  logic [ADDR_W-1:0] q_addr[$];
  int                q_len[$];
  int                cur_k = 0;
  int                beat_no = 0;
  logic [ADDR_W-1:0] ar_addr_log[$];
  int                ar_len_log[$];
  logic [DATA_W-1:0] got[$];
  int                done_cnt = 0;
  int                rready_low = 0;

  logic [ADDR_W-1:0] exp_addr[$];
  int                exp_len[$];
  logic [DATA_W-1:0] exp_data[$];

  always #5 clk = ~clk;

  ddr4_frame_reader dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .base_addr_i   (base),
    .frame_beats_i (frame_beats),
    .m_axi_araddr  (araddr),
    .m_axi_arlen   (arlen),
    .m_axi_arsize  (arsize),
    .m_axi_arburst (arburst),
    .m_axi_arid    (arid),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .m_axi_rlast   (rlast),
    .m_axi_rid     (rid),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready),
    .pix_data_o    (pix_data),
    .pix_valid_o   (pix_valid),
    .pix_ready_i   (pix_ready),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
  );

  function automatic logic [DATA_W-1:0] data_of(input logic [31:0] s, input logic [ADDR_W-1:0] a);
    return {s, 1'b0, a};
  endfunction

  // Reference: bursts of min(BURST_LEN, remaining) beats from base; data is a pure function of address.
  function automatic void build_exp(input logic [ADDR_W-1:0] b, input int n);
    int rem;
    int k;
    logic [ADDR_W-1:0] a;
    exp_addr.delete(); exp_len.delete(); exp_data.delete();
    for (int i = 0; i < n; i++) exp_data.push_back(data_of(seed, b + ADDR_W'(i * 8)));
    rem = n;
    a = b;
    while (rem > 0) begin
      k = (rem < BURST_LEN) ? rem : BURST_LEN;
      exp_addr.push_back(a);
      exp_len.push_back(k - 1);
      a = a + ADDR_W'(k * 8);
      rem -= k;
    end
  endfunction

  // AXI slave, stream sink and monitors, all acting on the falling edge.
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = AXI_RESP_OKAY; rlast = 1'b0; rid = '0;
    pix_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q_addr.delete(); q_len.delete(); cur_k = 0;
        rvalid = 1'b0; arready = 1'b0; pix_ready = 1'b0; rlast = 1'b0;
        continue;
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = AXI_RESP_OKAY;
      if (q_len.size() > 0 && $urandom_range(99) < r_pct) begin
        rvalid = 1'b1;
        rdata  = data_of(seed, q_addr[0] + ADDR_W'(cur_k * 8));
        rlast  = (cur_k == q_len[0]) || (beat_no == early_last_beat);
        rresp  = (beat_no == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        rid    = ID_W'($urandom);
        beat_no++;
        if (cur_k == q_len[0]) begin
          cur_k = 0;
          void'(q_addr.pop_front());
          void'(q_len.pop_front());
        end else cur_k++;
      end
      arready = !ar_force_low && ($urandom_range(99) < ar_pct);
      if (arvalid && arready) begin
        q_addr.push_back(araddr); q_len.push_back(int'(arlen));
        ar_addr_log.push_back(araddr); ar_len_log.push_back(int'(arlen));
      end
      pix_ready = ($urandom_range(99) < pix_pct);
      if (pix_valid && pix_ready) got.push_back(pix_data);
      if (done) done_cnt++;
      if (!rready) rready_low++;
    end
  end

  task automatic start_frame(input logic [ADDR_W-1:0] b, input int n);
    @(posedge clk); #1;
    ar_addr_log.delete(); ar_len_log.delete(); got.delete();
    done_cnt = 0; beat_no = 0; seed = $urandom;
    base = b; frame_beats = BEATS_W'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_frame(input int n, output bit ok);
    int cyc = 0;
    while (!(done_cnt > 0 && got.size() >= n && !pix_valid) && cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = (cyc < 6000);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %b want 0", arvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got %b want 0", pix_valid); end
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL reset_rready got %b want 1", rready); end
    checks++; if (arsize !== 3'd3 || arburst !== 2'b01 || arid !== '0) begin
      errors++; $display("FAIL ar_consts got size %0d burst %0d id %0d want 3 1 0", arsize, arburst, arid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    bit ok;
    ar_pct = 100; r_pct = 100; pix_pct = 100;
    start_frame(31'h1000, 40);
    build_exp(31'h1000, 40);
    wait_frame(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got done %0d words %0d want 1 40", done_cnt, got.size()); end
    checks++; if (ar_addr_log.size() != 3) begin errors++; $display("FAIL basic_ar_count got %0d want 3", ar_addr_log.size()); end
    for (int i = 0; i < exp_addr.size() && i < ar_addr_log.size(); i++) begin
      checks++;
      if (ar_addr_log[i] !== exp_addr[i] || ar_len_log[i] != exp_len[i]) begin
        errors++; $display("FAIL basic_ar%0d got %h/%0d want %h/%0d", i, ar_addr_log[i], ar_len_log[i], exp_addr[i], exp_len[i]);
      end
    end
    checks++; if (got.size() != 40) begin errors++; $display("FAIL basic_words got %0d want 40", got.size()); end
    for (int i = 0; i < exp_data.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_data[i]) begin errors++; $display("FAIL basic_word%0d got %h want %h", i, got[i], exp_data[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt); end
    checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_flags got err %b busy %b want 0 0", err, busy); end
  endtask

  task automatic test_backpressure;
    bit ok;
    int bad = 0;
    ar_pct = 100; r_pct = 100; pix_pct = 0; rready_low = 0;
    start_frame(31'h20000, 256);
    build_exp(31'h20000, 256);
    repeat (200) @(posedge clk);
    #1;
    checks++; if (ar_addr_log.size() != FIFO_DEPTH / BURST_LEN) begin
      errors++; $display("FAIL bp_ar_count got %0d want %0d", ar_addr_log.size(), FIFO_DEPTH / BURST_LEN);
    end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL bp_arvalid got %b want 0", arvalid); end
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL bp_pix_valid got %b want 1", pix_valid); end
    pix_pct = 100;
    wait_frame(256, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got words %0d want 256", got.size()); end
    checks++; if (ar_addr_log.size() != exp_addr.size()) begin errors++; $display("FAIL bp_ar_total got %0d want %0d", ar_addr_log.size(), exp_addr.size()); end
    checks++; if (got.size() != 256) begin errors++; $display("FAIL bp_words got %0d want 256", got.size()); end
    for (int i = 0; i < exp_data.size() && i < got.size(); i++) if (got[i] !== exp_data[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_data got %0d wrong words want 0", bad); end
    checks++; if (rready_low != 0) begin errors++; $display("FAIL bp_rready got %0d low cycles want 0", rready_low); end
  endtask

  task automatic test_ar_stall;
    bit ok;
    int cyc = 0;
    logic [ADDR_W-1:0] a0;
    logic [7:0] l0;
    ar_pct = 100; r_pct = 100; pix_pct = 100; ar_force_low = 1'b1;
    start_frame(31'h6000, 20);
    build_exp(31'h6000, 20);
    while (!arvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL stall_arvalid got %b want 1", arvalid); end
    a0 = araddr; l0 = arlen;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (arvalid !== 1'b1 || araddr !== a0 || arlen !== l0) begin
        errors++; $display("FAIL stall_hold%0d got %b %h %0d want 1 %h %0d", i, arvalid, araddr, arlen, a0, l0);
      end
    end
    ar_force_low = 1'b0;
    wait_frame(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got words %0d want 20", got.size()); end
    checks++; if (ar_addr_log.size() != 2 || ar_addr_log[0] !== 31'h6000 || ar_len_log[0] != 15) begin
      errors++; $display("FAIL stall_ar got %0d bursts want 2 starting 6000/15", ar_addr_log.size());
    end
    checks++; if (got.size() != 20 || got[19] !== exp_data[19]) begin errors++; $display("FAIL stall_data got %0d words want 20 matching", got.size()); end
  endtask

  task automatic test_error;
    bit ok;
    ar_pct = 80; r_pct = 80; pix_pct = 100; err_beat = 5;
    start_frame(31'h8000, 32);
    build_exp(31'h8000, 32);
    wait_frame(32, ok);
    checks++; if (!ok) begin errors++; $display("FAIL err_timeout got words %0d want 32", got.size()); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL err_done got %0d want 1", done_cnt); end
    checks++; if (got.size() != 32 || got[5] !== exp_data[5]) begin errors++; $display("FAIL err_data got %0d words want 32 matching", got.size()); end
    err_beat = -1;
    start_frame(31'h9000, 8);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear_on_start got %b want 0", err); end
    wait_frame(8, ok);
    checks++; if (!ok || err !== 1'b0) begin errors++; $display("FAIL err_clean_frame got ok %b err %b want 1 0", ok, err); end
  endtask

  task automatic test_protocol;
    bit ok;
    ar_pct = 100; r_pct = 100; pix_pct = 100; early_last_beat = 3;
    start_frame(31'h4000, 16);
    build_exp(31'h4000, 16);
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL proto_busy got %b want 1", busy); end
    base = 31'h7000; frame_beats = 24'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_frame(16, ok);
    early_last_beat = -1;
    checks++; if (!ok) begin errors++; $display("FAIL proto_timeout got words %0d want 16", got.size()); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL proto_early_rlast got err %b want 1", err); end
    checks++; if (ar_addr_log.size() != 1 || ar_addr_log[0] !== 31'h4000) begin
      errors++; $display("FAIL proto_busy_start got %0d bursts want 1 at 4000", ar_addr_log.size());
    end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done_cnt != 1) begin errors++; $display("FAIL proto_ignored got busy %b done %0d want 0 1", busy, done_cnt); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int cyc = 0;
    int bad = 0;
    ar_pct = 100; r_pct = 100; pix_pct = 0;
    start_frame(31'hA000, 64);
    while (beat_no <= 20 && cyc < 500) begin @(posedge clk); #1; cyc++; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (arvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || pix_valid !== 1'b0 || rready !== 1'b1) begin
      errors++; $display("FAIL midreset_outputs got arv %b busy %b done %b err %b pv %b rr %b want 0 0 0 0 0 1",
                         arvalid, busy, done, err, pix_valid, rready);
    end
    rst_n = 1'b1;
    pix_pct = 100;
    start_frame(31'hB000, 8);
    build_exp(31'hB000, 8);
    wait_frame(8, ok);
    checks++; if (!ok || got.size() != 8) begin errors++; $display("FAIL midreset_fresh got ok %b words %0d want 1 8", ok, got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) if (got[i] !== exp_data[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL midreset_data got %0d wrong words want 0", bad); end
  endtask

  task automatic test_random;
    bit ok;
    int n;
    int bad;
    logic [ADDR_W-1:0] b;
    for (int it = 0; it < 5; it++) begin
      ar_pct = $urandom_range(30, 100); r_pct = $urandom_range(30, 100); pix_pct = $urandom_range(20, 100);
      n = (it == 0) ? 40 : $urandom_range(1, 150);
      b = (it == 0) ? 31'h7FFFFF80 : (ADDR_W'($urandom) & ~ADDR_W'(127));
      start_frame(b, n);
      build_exp(b, n);
      wait_frame(n, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout got words %0d want %0d", it, got.size(), n); end
      bad = 0;
      if (ar_addr_log.size() != exp_addr.size()) bad++;
      for (int i = 0; i < exp_addr.size() && i < ar_addr_log.size(); i++)
        if (ar_addr_log[i] !== exp_addr[i] || ar_len_log[i] != exp_len[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d_ar got %0d bad bursts of %0d want 0", it, bad, exp_addr.size()); end
      bad = 0;
      if (got.size() != n) bad++;
      for (int i = 0; i < n && i < got.size(); i++) if (got[i] !== exp_data[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d_data got %0d bad of %0d words want 0", it, bad, n); end
      checks++; if (done_cnt != 1 || err !== 1'b0) begin errors++; $display("FAIL rand%0d_flags got done %0d err %b want 1 0", it, done_cnt, err); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_ar_stall;
    test_error;
    test_protocol;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d checks want completion", checks);
    $fatal(1);
  end

endmodule
